hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Drives PC write-enable, IF/ID WriteEnable, IF/ID flush (br_taken path) and the ID/EX bubble.
- Detects load-use and register-branch operand hazards from the IF/ID decode taps (IFIDrs/rt, IFIDBranch, IFIDBranchReg, IFIDHLT).
- Sequences HLT drain and freezes the pipe on memory wait; also keeps a saturating stall counter.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use / register-branch hazard stalls,
// HLT drain to a terminal halted state, memory-wait freeze and a stall counter.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       IFIDrs,
  input  logic [3:0]       IFIDrt,
  input  logic             IFIDBranch,
  input  logic             IFIDBranchReg,
  input  logic             IFIDHLT,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [3:0]       IDEX_rd,
  input  logic             EXMEM_MemRead,
  input  logic [3:0]       EXMEM_rd,
  input  logic             br_cond,
  input  logic             mem_stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             br_taken,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 4) ? $clog2(DRAIN_CYCLES) : 2;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [DW-1:0]    drain_r, drain_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_nxt_s;
  logic             hazard_s;

  // A source register only creates a dependency when it is not r0.
  function automatic logic reg_match(input logic [3:0] dst, input logic [3:0] src);
    return (dst != 4'd0) && (dst == src);
  endfunction

  // Hazard detection from the ID decode taps against EX/MEM destinations.
  always_comb begin
    hazard_s = (IDEX_MemRead && (reg_match(IDEX_rd, IFIDrs) || reg_match(IDEX_rd, IFIDrt)))
            || (IFIDBranchReg && IDEX_RegWrite && reg_match(IDEX_rd, IFIDrs))
            || (IFIDBranchReg && EXMEM_MemRead && reg_match(EXMEM_rd, IFIDrs));
  end

  // State, drain counter and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      drain_r     <= {DW{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drain_r     <= drain_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
    end
  end

  // Next-state logic; a memory wait freezes every piece of state.
  always_comb begin
    state_nxt_s     = state_r;
    drain_nxt_s     = drain_r;
    stall_cnt_nxt_s = stall_cnt_r;
    if (mem_stall) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        RUN: begin
          if (hazard_s) begin
            if (stall_cnt_r != {CNT_W{1'b1}}) begin
              stall_cnt_nxt_s = stall_cnt_r + CNT_W'(1);
            end else begin
              stall_cnt_nxt_s = stall_cnt_r;
            end
          end else if (IFIDHLT) begin
            state_nxt_s = DRAIN;
            drain_nxt_s = {DW{1'b0}};
          end else begin
            state_nxt_s = RUN;
          end
        end
        DRAIN: begin
          if (drain_r == DRAIN_LAST) begin
            state_nxt_s = HALTED;
          end else begin
            drain_nxt_s = drain_r + DW'(1);
          end
        end
        HALTED:  state_nxt_s = HALTED;
        default: state_nxt_s = RUN;
      endcase
    end
  end

  // Pipeline control outputs, forced low while reset is held.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    br_taken    = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      halted = 1'b0;
    end else begin
      halted = (state_r == HALTED);
      if (mem_stall) begin
        idex_bubble = 1'b0;
      end else begin
        case (state_r)
          HALTED, DRAIN: idex_bubble = 1'b1;
          RUN: begin
            if (hazard_s || IFIDHLT) begin
              idex_bubble = 1'b1;
            end else begin
              pc_we    = 1'b1;
              ifid_we  = 1'b1;
              br_taken = IFIDBranch & br_cond;
            end
          end
          default: idex_bubble = 1'b1;
        endcase
      end
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; a second instance with CNT_W=2 checks saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  IFIDrs, IFIDrt, IDEX_rd, EXMEM_rd;
  logic        IFIDBranch, IFIDBranchReg, IFIDHLT;
  logic        IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead, br_cond, mem_stall;
  logic        pc_we, ifid_we, br_taken, idex_bubble, halted;
  logic [15:0] stall_cnt;
  logic        pc_we_s2, ifid_we_s2, br_taken_s2, idex_bubble_s2, halted_s2;
  logic [1:0]  stall_cnt_s2;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFIDBranch(IFIDBranch),
    .IFIDBranchReg(IFIDBranchReg), .IFIDHLT(IFIDHLT), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_rd(IDEX_rd), .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_rd(EXMEM_rd), .br_cond(br_cond), .mem_stall(mem_stall), .pc_we(pc_we),
    .ifid_we(ifid_we), .br_taken(br_taken), .idex_bubble(idex_bubble), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFIDBranch(IFIDBranch),
    .IFIDBranchReg(IFIDBranchReg), .IFIDHLT(IFIDHLT), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_rd(IDEX_rd), .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_rd(EXMEM_rd), .br_cond(br_cond), .mem_stall(mem_stall), .pc_we(pc_we_s2),
    .ifid_we(ifid_we_s2), .br_taken(br_taken_s2), .idex_bubble(idex_bubble_s2),
    .halted(halted_s2), .stall_cnt(stall_cnt_s2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic e_pc, input logic e_ifid,
                            input logic e_bub, input logic e_br, input logic e_halt);
    check({tag, ".pc_we"},       32'(pc_we),       32'(e_pc));
    check({tag, ".ifid_we"},     32'(ifid_we),     32'(e_ifid));
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
    check({tag, ".br_taken"},    32'(br_taken),    32'(e_br));
    check({tag, ".halted"},      32'(halted),      32'(e_halt));
  endtask

  task automatic idle();
    IFIDrs = 4'd0; IFIDrt = 4'd0; IDEX_rd = 4'd0; EXMEM_rd = 4'd0;
    IFIDBranch = 1'b0; IFIDBranchReg = 1'b0; IFIDHLT = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; EXMEM_MemRead = 1'b0;
    br_cond = 1'b0; mem_stall = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    adv();
    rst = 1'b1;
  endtask

  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    idle();
    rst = 1'b0;
    // Reset: everything low for two cycles, then free-running fetch
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      expect_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
      adv();
    end
    rst = 1'b1;
    @(negedge clk);
    expect_ctl("release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("release.stall_cnt", 32'(stall_cnt), 32'd0);
    adv();

    // Load-use on rs
    IDEX_MemRead = 1'b1; IDEX_rd = 4'd4; IFIDrs = 4'd4;
    @(negedge clk);
    expect_ctl("lu_rs", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    IDEX_MemRead = 1'b0;
    @(negedge clk);
    expect_ctl("lu_rs_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs.stall_cnt", 32'(stall_cnt), 32'd1);
    adv();
    // Load to r0 never stalls
    IDEX_MemRead = 1'b1; IDEX_rd = 4'd0; IFIDrs = 4'd0; IFIDrt = 4'd0;
    @(negedge clk);
    expect_ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();
    check("lu_r0.stall_cnt", 32'(stall_cnt), 32'd1);
    // Load-use on rt
    IDEX_rd = 4'd5; IFIDrs = 4'd1; IFIDrt = 4'd5;
    @(negedge clk);
    expect_ctl("lu_rt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    check("lu_rt.stall_cnt", 32'(stall_cnt), 32'd2);

    // BR on an ALU result in EX: one stall, then a single taken cycle
    idle();
    IFIDBranch = 1'b1; IFIDBranchReg = 1'b1; br_cond = 1'b1;
    IDEX_RegWrite = 1'b1; IDEX_rd = 4'd7; IFIDrs = 4'd7;
    @(negedge clk);
    expect_ctl("br_ex", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    IDEX_RegWrite = 1'b0;
    @(negedge clk);
    expect_ctl("br_ex_resolve", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("br_ex.stall_cnt", 32'(stall_cnt), 32'd3);
    adv();
    // Non-register branch ignores an EX writer; condition false means not taken
    idle();
    IFIDBranch = 1'b1; br_cond = 1'b0; IDEX_RegWrite = 1'b1; IDEX_rd = 4'd7; IFIDrs = 4'd7;
    @(negedge clk);
    expect_ctl("b_nottaken", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();

    // Load followed by dependent BR: two stalls, then taken for exactly one cycle
    do_reset();
    IFIDBranch = 1'b1; IFIDBranchReg = 1'b1; br_cond = 1'b1; IFIDrs = 4'd3;
    IDEX_MemRead = 1'b1; IDEX_rd = 4'd3;
    @(negedge clk);
    expect_ctl("ldbr_c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    IDEX_MemRead = 1'b0; IDEX_rd = 4'd0; EXMEM_MemRead = 1'b1; EXMEM_rd = 4'd3;
    @(negedge clk);
    expect_ctl("ldbr_c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    EXMEM_MemRead = 1'b0; EXMEM_rd = 4'd0;
    @(negedge clk);
    expect_ctl("ldbr_c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ldbr.stall_cnt", 32'(stall_cnt), 32'd2);
    adv();
    idle();
    @(negedge clk);
    expect_ctl("ldbr_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();

    // Memory wait freezes a pending load-use stall
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_rd = 4'd4; IFIDrs = 4'd4; mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_ctl("memwait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      adv();
      check("memwait.stall_cnt", 32'(stall_cnt), 32'd0);
    end
    mem_stall = 1'b0;
    @(negedge clk);
    expect_ctl("memwait_resume", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    check("memwait_resume.stall_cnt", 32'(stall_cnt), 32'd1);
    idle();
    @(negedge clk);
    expect_ctl("memwait_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();

    // HLT drain: halted four cycles after HLT sits in ID, then held
    do_reset();
    IFIDHLT = 1'b1;
    @(negedge clk);
    expect_ctl("hlt_t0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    IFIDHLT = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) begin
        IFIDBranch = 1'b1; br_cond = 1'b1;
      end
      @(negedge clk);
      expect_ctl($sformatf("hlt_t%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, (i >= 4) ? 1'b1 : 1'b0);
      adv();
    end

    // Reset while halted drops halted immediately and restarts in RUN
    rst = 1'b0;
    idle();
    @(negedge clk);
    expect_ctl("rst_halted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    rst = 1'b1;
    @(negedge clk);
    expect_ctl("rst_halted_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();

    // HLT drain with a two-cycle memory wait two cycles in
    IFIDHLT = 1'b1;
    adv();
    IFIDHLT = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      mem_stall = (i == 2 || i == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      check($sformatf("hlt_ms_t%0d.halted", i), 32'(halted), (i >= 6) ? 32'd1 : 32'd0);
      check($sformatf("hlt_ms_t%0d.idex_bubble", i), 32'(idex_bubble), mem_stall ? 32'd0 : 32'd1);
      adv();
    end

    // Saturating counter on the 2-bit instance
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_rd = 4'd9; IFIDrt = 4'd9;
    for (int i = 0; i < 5; i++) begin
      adv();
      check($sformatf("sat_%0d.stall_cnt", i), 32'(stall_cnt_s2), 32'(sat_exp[i]));
    end
    check("sat.wide_stall_cnt", 32'(stall_cnt), 32'd5);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
